// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and the column painter state encoding.
// Imported by every block that touches the 640x480 1-bit framebuffer.
package vga_pkg;

   localparam int WIDTH  = 640;
   localparam int HEIGHT = 480;

   localparam logic COLOR_BLACK = 1'b0;
   localparam logic COLOR_WHITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SWEEP = 2'd2,
      WAIT  = 2'd3
   } painter_state_t;

endpackage

// File: rtl/column_painter.sv
// Single write port into the framebuffer: paints cleared columns black while
// listen is high, otherwise forwards line-drawer pixels as white.
module column_painter
   import vga_pkg::*;
#(
   parameter int WIDTH  = vga_pkg::WIDTH,
   parameter int HEIGHT = vga_pkg::HEIGHT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       listen,
   input  logic       drawer_reset,
   input  logic [9:0] x,
   input  logic [9:0] draw_x,
   input  logic [8:0] draw_y,
   input  logic       draw_valid,
   output logic [9:0] pixel_x,
   output logic [8:0] pixel_y,
   output logic       pixel_color,
   output logic       pixel_write,
   output logic       column_done,
   output logic       busy,
   output logic [1:0] state_dbg
);

   localparam logic [9:0] COL_LIMIT = 10'(WIDTH);
   localparam logic [8:0] LAST_ROW  = 9'(HEIGHT - 1);

   painter_state_t state, state_n;
   logic [9:0] col, col_n;
   logic [8:0] row, row_n;
   logic [9:0] pixel_x_n;
   logic [8:0] pixel_y_n;
   logic       pixel_color_n;
   logic       pixel_write_n;
   logic       column_done_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         pixel_color <= COLOR_BLACK;
         pixel_write <= 1'b0;
         column_done <= 1'b0;
      end else begin
         state       <= state_n;
         col         <= col_n;
         row         <= row_n;
         pixel_x     <= pixel_x_n;
         pixel_y     <= pixel_y_n;
         pixel_color <= pixel_color_n;
         pixel_write <= pixel_write_n;
         column_done <= column_done_n;
      end
   end

   // listen is tested before drawer_reset in every clear-mode state so that
   // dropping it always wins, abandoning any half-painted column.
   always_comb begin
      state_n       = state;
      col_n         = col;
      row_n         = row;
      pixel_x_n     = pixel_x;
      pixel_y_n     = pixel_y;
      pixel_color_n = pixel_color;
      pixel_write_n = 1'b0;
      column_done_n = 1'b0;
      case (state)
         IDLE: begin
            if (listen) begin
               pixel_color_n = COLOR_BLACK;
               if (drawer_reset) begin
                  state_n = ARMED;
                  col_n   = x;
                  row_n   = '0;
               end else begin
                  state_n = WAIT;
               end
            end else begin
               pixel_write_n = draw_valid;
               pixel_x_n     = draw_x;
               pixel_y_n     = draw_y;
               pixel_color_n = COLOR_WHITE;
            end
         end
         ARMED: begin
            if (!listen) begin
               state_n = IDLE;
            end else if (drawer_reset) begin
               col_n = x;
               row_n = '0;
            end else begin
               state_n = SWEEP;
            end
         end
         SWEEP: begin
            if (!listen) begin
               state_n = IDLE;
            end else if (drawer_reset) begin
               state_n = ARMED;
               col_n   = x;
               row_n   = '0;
            end else begin
               // Off-screen columns still sweep so the column period stays fixed.
               pixel_x_n     = col;
               pixel_y_n     = row;
               pixel_color_n = COLOR_BLACK;
               pixel_write_n = (col < COL_LIMIT);
               if (row == LAST_ROW) begin
                  state_n       = WAIT;
                  row_n         = '0;
                  column_done_n = 1'b1;
               end else begin
                  row_n = row + 9'd1;
               end
            end
         end
         WAIT: begin
            if (!listen) begin
               state_n = IDLE;
            end else if (drawer_reset) begin
               state_n = ARMED;
               col_n   = x;
               row_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy      = (state == ARMED) || (state == SWEEP);
   assign state_dbg = state;

endmodule

// File: doc/column_painter.md
# column_painter

Sink end of the screen-clear interface, and the single write port into the 640x480 1-bit VGA framebuffer. While `listen` is high, it latches the column `x` on each `drawer_reset` burst and then paints that column black, one pixel per cycle for y = 0..479. While `listen` is low, it forwards line-drawer pixels to the framebuffer as white. It sits between the screen clearer / line drawer pair and the framebuffer write port.

## Interface
Parameters:
- `WIDTH`, 640, visible columns; `x >= WIDTH` is never written.
- `HEIGHT`, 480, rows swept per column.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `listen`  in  1  clear operation in progress; selects clear mode.
- `drawer_reset`  in  1  column-start burst, high for several cycles per column.
- `x`  in  10  column to clear, sampled while `drawer_reset` is high.
- `draw_x`  in  10  line-drawer pixel x.
- `draw_y`  in  9  line-drawer pixel y.
- `draw_valid`  in  1  line-drawer pixel strobe.
- `pixel_x`  out  10  framebuffer write x.
- `pixel_y`  out  9  framebuffer write y.
- `pixel_color`  out  1  1 = white, 0 = black.
- `pixel_write`  out  1  framebuffer write enable.
- `column_done`  out  1  one-cycle pulse after row HEIGHT-1 of a column is issued.
- `busy`  out  1  high in ARMED or SWEEP.

## Operation
- States:
  - IDLE: pass-through.
  - ARMED: `drawer_reset` seen; column latched.
  - SWEEP: painting the column.
  - WAIT: column finished; awaiting the next burst.
- IDLE:
  - Registered pass-through: `pixel_write <= draw_valid`, `pixel_x <= draw_x`, `pixel_y <= draw_y`, `pixel_color <= 1`.
  - `listen` high -> WAIT, or -> ARMED if `drawer_reset` is also high.
- Clear mode (`listen` high):
  - Line-drawer inputs are ignored.
  - `pixel_color` is 0.
- ARMED:
  - Every cycle with `drawer_reset` high: `col <= x`, `row <= 0`.
  - The last latched x wins.
  - `drawer_reset` low -> SWEEP.
- SWEEP:
  - Each cycle: `pixel_x <= col`, `pixel_y <= row`.
  - `pixel_write <= (col < WIDTH)`.
  - `row <= row + 1`.
  - Issuing row HEIGHT-1 -> WAIT, with `column_done` asserted.
- WAIT:
  - No writes.
  - `drawer_reset` high -> ARMED.
- `drawer_reset` high during SWEEP: abort the current column (no `column_done`), enter ARMED, latch the new x.
- `listen` low in any clear-mode state -> IDLE next cycle.
  - Pass-through resumes the cycle after that.
  - An unfinished column is abandoned.
- `listen` has priority over `drawer_reset`.
- `row` is 9 bits and never exceeds HEIGHT-1. `col` is 10 bits; values 640..1023 produce no writes but still sweep and pulse `column_done`.

## Timing
- Reset values:
  - state IDLE.
  - `pixel_x = 0`, `pixel_y = 0`, `pixel_color = 0`.
  - `pixel_write = 0`, `column_done = 0`, `busy = 0`.
  - `col = 0`, `row = 0`.
- Reset mid-sweep: all of the above on the next edge; no further writes.
- Pass-through latency: 1 cycle, input to write.
- Sweep timing:
  - First black write (row 0) appears 1 cycle after `drawer_reset` is first sampled low.
  - Row r appears r cycles after that.
  - `column_done` is registered with the row HEIGHT-1 write.
- Column period: burst length + HEIGHT + 1 cycles. This fits the clearer's 500-cycle column period with 6-cycle bursts.
- Throughput: one pixel per cycle, no backpressure; the framebuffer accepts every write.

## Structure
- Shared package `vga_pkg`:
  - `WIDTH`/`HEIGHT` default constants.
  - `painter_state_t` enum {IDLE, ARMED, SWEEP, WAIT}.
  - Color constants `COLOR_BLACK` = 0, `COLOR_WHITE` = 1.
- No sub-module: one state register, `col`/`row` registers, and the registered output mux.

## Test plan
- Pass-through:
  - Stimulus: `listen`=0, `draw_valid`=1, `draw_x`=100, `draw_y`=50.
  - Response: next cycle `pixel_write`=1, (100,50), `pixel_color`=1.
  - Stimulus: `draw_valid`=0. Response: `pixel_write`=0.
- Single column:
  - Stimulus: `listen`=1; `drawer_reset` high 6 cycles with `x`=7, then low.
  - Response: 480 consecutive writes (7,0)..(7,479), color 0.
  - `column_done` high exactly with (7,479); `busy` low the cycle after.
- Off-screen column:
  - Stimulus: `x`=640 burst.
  - Response: no `pixel_write` for 480 cycles; `column_done` still pulses once.
- Abort by new burst:
  - Stimulus: `drawer_reset` reasserted with `x`=9 at row 200 of column 8.
  - Response: no `column_done` for column 8; the sweep restarts at (9,0).
- `listen` drop mid-sweep:
  - Stimulus: `listen`=0 at row 100 while `draw_valid`=1 at (3,4).
  - Response: black writes stop; the white write (3,4) appears 2 cycles after the drop.
- Reset mid-sweep:
  - Stimulus: `reset`=1 for 1 cycle at row 300.
  - Response: all outputs at reset values next cycle.
  - With `listen`=1 and no `drawer_reset` after reset, no writes until the next burst.
